// File: rtl/dff_pkg.sv
// dff_pkg: shared defaults and counter-width helper for the dff_pipe family
package dff_pkg;

    localparam int DFF_DEF_WIDTH = 8;
    localparam int DFF_DEF_DEPTH = 3;

    function automatic int dff_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// dff_pipe_stage: one valid bit plus a data register that moves only when the stage may advance
module dff_pipe_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clr,
    input  logic             i_adv,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // take the upstream valid when advancing; data is loaded only behind a valid so bubbles keep the old word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= RESET_VAL;
        end else if (i_clr) begin
            r_valid <= 1'b0;
            r_data  <= RESET_VAL;
        end else if (i_adv) begin
            r_valid <= i_valid;
            if (i_valid) r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH x DEPTH valid/ready register pipeline with collapsing bubbles; DFF_PIPE_COUNT_EN adds an occupancy count port
module dff_pipe
    import dff_pkg::*;
#(
    parameter int               WIDTH     = DFF_DEF_WIDTH,
    parameter int               DEPTH     = DFF_DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
`ifdef DFF_PIPE_COUNT_EN
    ,
    output logic [dff_cnt_w(DEPTH)-1:0] count
`endif
);

    logic [DEPTH-1:0] w_v;
    logic [DEPTH-1:0] w_adv;
    logic [WIDTH-1:0] w_r [DEPTH];

    // a stage moves when its successor moves or when it is empty, so bubbles collapse under a stall
    assign w_adv[DEPTH-1] = out_ready | ~w_v[DEPTH-1];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             w_vin;
        logic [WIDTH-1:0] w_din;
        if (i == 0) begin : g_first
            assign w_vin = in_valid;
            assign w_din = d;
        end else begin : g_next
            assign w_vin = w_v[i-1];
            assign w_din = w_r[i-1];
        end
        if (i < DEPTH - 1) begin : g_adv
            assign w_adv[i] = w_adv[i+1] | ~w_v[i];
        end
        dff_pipe_stage #(
            .WIDTH    (WIDTH),
            .RESET_VAL(RESET_VAL)
        ) u_stage (
            .clk    (clk),
            .reset_n(reset_n),
            .i_clr  (clr),
            .i_adv  (w_adv[i]),
            .i_valid(w_vin),
            .i_data (w_din),
            .o_valid(w_v[i]),
            .o_data (w_r[i])
        );
    end

    assign in_ready  = w_adv[0];
    assign out_valid = w_v[DEPTH-1];
    assign q         = w_r[DEPTH-1];
    assign qb        = ~w_r[DEPTH-1];

`ifdef DFF_PIPE_COUNT_EN
    localparam int               CNT_W   = dff_cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] r_count;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    // occupancy follows net transfers; a simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)             r_count <= '0;
        else if (clr)             r_count <= '0;
        else if (w_push & ~w_pop) r_count <= r_count + 1'b1;
        else if (w_pop & ~w_push) r_count <= r_count - 1'b1;
    end

    // occupancy can never exceed the number of stages
    always @(posedge clk) begin
        if (reset_n) assert (r_count <= CNT_MAX);
    end

    assign count = r_count;
`endif

endmodule
